// File: rtl/quad_sample_scheduler_pkg.sv
// Shared definitions for the quadrature sample scheduler: default widths,
// FSM state encoding and the channel-index width helper.
package quad_sample_scheduler_pkg;

    localparam int DEF_CNT_W = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/quad_tick_gen.sv
// Sample-rate prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle.
module quad_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    assign tick = enable && (presc == LAST);

    // Prescaler: parked at 0 while disabled, wraps to 0 on the tick edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (!enable || presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/quad_sample_scheduler.sv
// Coherent snapshot of all encoder counters at a fixed rate, streamed out one
// channel per record with the delta since the previous snapshot.
//
//   state | meaning
//   IDLE  | waiting for the next sample tick
//   EMIT  | presenting record for channel ch until the host accepts it
module quad_sample_scheduler
    import quad_sample_scheduler_pkg::*;
#(
    parameter int NUM_ENC     = 6,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CLK_FREQ_HZ = 32_000_000,
    parameter int SAMPLE_HZ   = 1000,
    localparam int CH_W       = ch_w(NUM_ENC)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_ENC*CNT_W-1:0] count_i,
    output logic                     sample_tick,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_channel,
    output logic [CNT_W-1:0]         out_position,
    output logic [CNT_W-1:0]         out_delta,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int DIV = CLK_FREQ_HZ / SAMPLE_HZ;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  snap [NUM_ENC];
    logic [CNT_W-1:0]  prev [NUM_ENC];
    logic              primed;
    logic              tick;
    logic              accept;
    logic              last_ch;

    quad_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign accept  = (state == ST_EMIT) && out_ready;
    assign last_ch = (ch == CH_W'(NUM_ENC - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and record outputs; the payload is a pure function of
    // registered state so it holds steady under backpressure.
    always_comb begin
        state_nxt    = state;
        out_valid    = 1'b0;
        out_channel  = '0;
        out_position = '0;
        out_delta    = '0;
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid    = 1'b1;
                out_channel  = ch;
                out_position = snap[ch];
                out_delta    = primed ? (snap[ch] - prev[ch]) : '0;
                if (accept && last_ch) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot capture, channel sequencing, previous-sample history and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch          <= '0;
            primed      <= 1'b0;
            sample_tick <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < NUM_ENC; k++) begin
                snap[k] <= '0;
                prev[k] <= '0;
            end
        end else begin
            sample_tick <= tick;
            // A tick landing mid-frame is dropped; set beats clear.
            if (tick && state == ST_EMIT) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (state == ST_IDLE && tick) begin
                for (int k = 0; k < NUM_ENC; k++) begin
                    snap[k] <= count_i[k*CNT_W +: CNT_W];
                end
                ch <= '0;
            end else if (accept) begin
                prev[ch] <= snap[ch];
                if (last_ch) begin
                    primed <= 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_sample_scheduler.sv
module tb_quad_sample_scheduler;

    localparam int NUM_ENC = 2;
    localparam int CNT_W   = 24;
    localparam int DIV     = 4;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     enable = 1'b0;
    logic [NUM_ENC*CNT_W-1:0] count_i = '0;
    logic                     sample_tick;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [0:0]               out_channel;
    logic [CNT_W-1:0]         out_position;
    logic [CNT_W-1:0]         out_delta;
    logic                     overrun;
    logic                     overrun_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    quad_sample_scheduler #(
        .NUM_ENC(NUM_ENC), .CNT_W(CNT_W), .CLK_FREQ_HZ(4000), .SAMPLE_HZ(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .count_i(count_i),
        .sample_tick(sample_tick), .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_position(out_position), .out_delta(out_delta),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (out_valid !== 1'b1 && n < 5 * DIV) begin
            step();
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s wait_valid: out_valid=%b required 1 within %0d cycles", nm, out_valid, 5 * DIV);
            miscompares++;
        end
    endtask

    // Sets the counts, then checks one full frame with out_ready held high.
    task automatic run_frame(input string nm, input logic [CNT_W-1:0] c0, c1, d0, d1);
        count_i = {c1, c0};
        out_ready = 1'b1;
        wait_valid(nm);
        vectors++;
        if ({sample_tick, out_channel, out_position, out_delta} !== {1'b1, 1'b0, c0, d0}) begin
            $display("FAIL %s rec0: tick/ch/pos/delta=%b/%0d/%h/%h required 1/0/%h/%h",
                     nm, sample_tick, out_channel, out_position, out_delta, c0, d0);
            miscompares++;
        end
        step();
        vectors++;
        if ({out_valid, sample_tick, out_channel, out_position, out_delta} !== {2'b10, 1'b1, c1, d1}) begin
            $display("FAIL %s rec1: valid/tick/ch/pos/delta=%b/%b/%0d/%h/%h required 1/0/1/%h/%h",
                     nm, out_valid, sample_tick, out_channel, out_position, out_delta, c1, d1);
            miscompares++;
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL %s end: out_valid=%b required 0", nm, out_valid);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count_i     = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
            enable      = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
            overrun_clr = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if ({sample_tick, out_valid, out_channel, out_position, out_delta, overrun} !== '0) begin
                $display("FAIL reset[%0d]: tick/valid/ch/pos/delta/ovr=%b/%b/%0d/%h/%h/%b required all 0",
                         i, sample_tick, out_valid, out_channel, out_position, out_delta, overrun);
                miscompares++;
            end
        end
        enable = 1'b1;
        out_ready = 1'b1;
        overrun_clr = 1'b0;
        count_i = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_first_frames();
        run_frame("frame1", 24'd10, 24'd20, 24'd0, 24'd0);
        run_frame("frame2", 24'd15, 24'd18, 24'd5, 24'hFFFFFE);
    endtask

    task automatic test_wrap();
        run_frame("wrap_a", 24'hFFFFFE, 24'h000100, 24'hFFFFEF, 24'h0000EE);
        run_frame("wrap_b", 24'h000003, 24'h000100, 24'd5, 24'd0);
    endtask

    task automatic test_backpressure();
        bit seen_tick = 1'b0;
        count_i = {24'd50, 24'd40};
        out_ready = 1'b0;
        wait_valid("bp");
        count_i = {24'd99, 24'd99};
        for (int i = 0; i < 6; i++) begin
            if (sample_tick && i > 0) seen_tick = 1'b1;
            vectors++;
            if ({out_valid, out_channel, out_position, out_delta} !== {1'b1, 1'b0, 24'd40, 24'd37}) begin
                $display("FAIL bp_hold[%0d]: valid/ch/pos/delta=%b/%0d/%h/%h required 1/0/28/25",
                         i, out_valid, out_channel, out_position, out_delta);
                miscompares++;
            end
            if (i < 5) step();
        end
        vectors++;
        if ({overrun, seen_tick} !== 2'b11) begin
            $display("FAIL bp_overrun: overrun/tick_seen=%b/%b required 1/1", overrun, seen_tick);
            miscompares++;
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if ({out_valid, out_channel, out_position, out_delta} !== {1'b1, 1'b1, 24'd50, 24'hFFFF32}) begin
            $display("FAIL bp_rec1: valid/ch/pos/delta=%b/%0d/%h/%h required 1/1/000032/ffff32",
                     out_valid, out_channel, out_position, out_delta);
            miscompares++;
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        vectors++;
        if ({out_valid, overrun} !== 2'b00) begin
            $display("FAIL bp_clear: valid/overrun=%b/%b required 0/0", out_valid, overrun);
            miscompares++;
        end
        run_frame("bp_next", 24'd99, 24'd99, 24'd59, 24'd49);
    endtask

    task automatic test_reset_mid_frame();
        count_i = {24'd300, 24'd200};
        out_ready = 1'b1;
        wait_valid("rst_mid");
        vectors++;
        if ({out_channel, out_position, out_delta} !== {1'b0, 24'd200, 24'd101}) begin
            $display("FAIL rst_mid_rec0: ch/pos/delta=%0d/%h/%h required 0/0000c8/000065",
                     out_channel, out_position, out_delta);
            miscompares++;
        end
        step();
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({sample_tick, out_valid, out_channel, out_position, out_delta, overrun} !== '0) begin
            $display("FAIL rst_mid_clear: tick/valid/ch/pos/delta/ovr=%b/%b/%0d/%h/%h/%b required all 0",
                     sample_tick, out_valid, out_channel, out_position, out_delta, overrun);
            miscompares++;
        end
        step();
        reset_n = 1'b1;
        run_frame("rst_unprimed", 24'd210, 24'd310, 24'd0, 24'd0);
    endtask

    task automatic test_enable_drop();
        bit bad_tick = 1'b0;
        bit bad_valid = 1'b0;
        count_i = {24'd330, 24'd220};
        out_ready = 1'b1;
        wait_valid("en_drop");
        enable = 1'b0;
        vectors++;
        if ({out_channel, out_position, out_delta} !== {1'b0, 24'd220, 24'd10}) begin
            $display("FAIL en_drop_rec0: ch/pos/delta=%0d/%h/%h required 0/0000dc/00000a",
                     out_channel, out_position, out_delta);
            miscompares++;
        end
        step();
        vectors++;
        if ({out_valid, out_channel, out_position, out_delta} !== {1'b1, 1'b1, 24'd330, 24'd20}) begin
            $display("FAIL en_drop_rec1: valid/ch/pos/delta=%b/%0d/%h/%h required 1/1/00014a/000014",
                     out_valid, out_channel, out_position, out_delta);
            miscompares++;
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            step();
            if (sample_tick !== 1'b0) bad_tick = 1'b1;
            if (out_valid !== 1'b0) bad_valid = 1'b1;
        end
        vectors++;
        if ({bad_tick, bad_valid} !== 2'b00) begin
            $display("FAIL en_drop_quiet: tick_seen/valid_seen=%b/%b required 0/0", bad_tick, bad_valid);
            miscompares++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_frames();
        test_wrap();
        test_backpressure();
        test_reset_mid_frame();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
